// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller and the
// Execute-stage operand muxes.
//   hazard_state_t : sequencing FSM states (START, RUN, MEMWAIT)
//   FWD_*          : operand forwarding select encodings
package hazard_pkg;

   typedef enum logic [1:0] {
      START   = 2'd0,
      RUN     = 2'd1,
      MEMWAIT = 2'd2
   } hazard_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;  // register file read data
   localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
   localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational operand-forwarding select for one Execute-stage
// source register.
//   rs_e_i        in  : Execute-stage source register index
//   rd_m_i        in  : Memory-stage destination register index
//   reg_write_m_i in  : Memory-stage write enable
//   rd_w_i        in  : Writeback-stage destination register index
//   reg_write_w_i in  : Writeback-stage write enable
//   fwd_o         out : FWD_MEM / FWD_WB / FWD_REG select
module forward_unit
   import hazard_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic [ADDR_WIDTH-1:0] rs_e_i,
   input  logic [ADDR_WIDTH-1:0] rd_m_i,
   input  logic                  reg_write_m_i,
   input  logic [ADDR_WIDTH-1:0] rd_w_i,
   input  logic                  reg_write_w_i,
   output logic [1:0]            fwd_o
);

   // Memory stage holds the younger value, so it wins over Writeback.
   // x0 is hardwired to zero and is never forwarded.
   always_comb begin
      fwd_o = FWD_REG;
      if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
         fwd_o = FWD_MEM;
      end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
// Produces forwarding selects, load-use stalls, branch flushes and sequences
// the Memory stage through multi-cycle data-memory accesses.
//   clk, rst (async, active low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, LoadE, PCSrcE, RdM/RdW, RegWriteM/RegWriteW,
//   MemAccessM, MemReadyM                       : pipeline status inputs
//   MemReqM                                     : access-start pulse
//   ForwardAE/ForwardBE                         : operand forwarding selects
//   StallF/D/E/M, FlushD/E/W                    : pipeline register controls
//   StallCycles, FlushCount, MemWaitCycles      : performance counters
// Build option: define HAZARD_PERF_CNT_EN to build the performance counters;
// otherwise the counter outputs are tied to zero.
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic                      LoadE,
   input  logic                      PCSrcE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteM,
   input  logic                      RegWriteW,
   input  logic                      MemAccessM,
   input  logic                      MemReadyM,
   output logic                      MemReqM,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      StallE,
   output logic                      StallM,
   output logic                      FlushD,
   output logic                      FlushE,
   output logic                      FlushW,
   output logic [CNT_WIDTH-1:0]      StallCycles,
   output logic [CNT_WIDTH-1:0]      FlushCount,
   output logic [CNT_WIDTH-1:0]      MemWaitCycles
);

   import hazard_pkg::*;

   hazard_state_t state_q, state_d;
   logic          lw;
   logic          mem_wait;

   forward_unit #(.ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .rs_e_i        (Rs1E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardAE)
   );

   forward_unit #(.ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .rs_e_i        (Rs2E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardBE)
   );

   assign lw = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // The first cycle of an access that misses its ready already counts as a
   // wait, so N low-ready cycles stall for exactly N cycles.
   assign mem_wait = ((state_q == RUN) && MemAccessM && !MemReadyM) ||
                     ((state_q == MEMWAIT) && !MemReadyM);

   // Only RUN can start an access; the MEMWAIT exit cycle never re-requests.
   assign MemReqM = (state_q == RUN) && MemAccessM;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         START:   state_d = RUN;
         RUN:     if (MemAccessM && !MemReadyM) state_d = MEMWAIT;
         MEMWAIT: if (MemReadyM) state_d = RUN;
         default: state_d = START;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= START;
      end else begin
         state_q <= state_d;
      end
   end

   // While a wait is active the branch/load in Execute is frozen in place,
   // so PCSrcE and lw are ignored until the first non-wait cycle.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (state_q == START) begin
         StallF = 1'b1;
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (mem_wait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw;
         StallD = lw;
         FlushD = PCSrcE;
         FlushE = lw || PCSrcE;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else if (state_q != START) begin
         if (StallF)   stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         if (FlushD)   flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
         if (mem_wait) wait_cnt_q  <= wait_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign StallCycles   = stall_cnt_q;
   assign FlushCount    = flush_cnt_q;
   assign MemWaitCycles = wait_cnt_q;
`else
   assign StallCycles   = '0;
   assign FlushCount    = '0;
   assign MemWaitCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Expected outputs are
// queued when stimulus is driven and compared on the following falling edge;
// asynchronous-reset behaviour is checked immediately without a clock edge.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       loade, pcsrce, rwm, rww, macc, mrdy;
   } vin_t;

   // {ForwardAE, ForwardBE, StallF/D/E/M, FlushD/E/W, MemReqM}
   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, sm, fd, fe, fw, req;
   } outs_t;

   typedef struct packed {
      outs_t       e;
      logic [31:0] tag;
   } sb_t;

   typedef struct packed {
      vin_t  i;
      outs_t e;
   } vec_t;

   logic        clk, rst;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        LoadE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM;
   logic        MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] StallCycles, FlushCount, MemWaitCycles;

   int unsigned errors = 0;
   int unsigned checks = 0;
   sb_t         sb[$];
   outs_t       act;

   hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .LoadE(LoadE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .MemReqM(MemReqM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .StallCycles(StallCycles), .FlushCount(FlushCount),
      .MemWaitCycles(MemWaitCycles)
   );

   assign act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, MemReqM};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   // Scoreboard consumer: compares queued expectations away from the rising edge.
   always @(negedge clk) begin
      sb_t it;
      if (sb.size() != 0) begin
         it = sb.pop_front();
         checks++;
         if (act !== it.e) begin
            errors++;
            $display("FAIL sb tag=%0d got=%b want=%b", it.tag, act, it.e);
         end
      end
   end

   function automatic vin_t V(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                              input logic loade, pcsrce,
                              input logic [4:0] rdm, input logic rwm,
                              input logic [4:0] rdw, input logic rww);
      vin_t v;
      v = '0;
      v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
      v.loade = loade; v.pcsrce = pcsrce;
      v.rdm = rdm; v.rwm = rwm; v.rdw = rdw; v.rww = rww;
      return v;
   endfunction

   task automatic set_in(input vin_t v);
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
      RdM = v.rdm; RdW = v.rdw; LoadE = v.loade; PCSrcE = v.pcsrce;
      RegWriteM = v.rwm; RegWriteW = v.rww;
      MemAccessM = v.macc; MemReadyM = v.mrdy;
   endtask

   // Drive one cycle of stimulus at posedge+1, queue its expectation.
   task automatic apply(input vin_t v, input outs_t e, input int unsigned tag);
      set_in(v);
      sb.push_back('{e: e, tag: 32'(tag)});
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string name, input outs_t e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, act, e);
      end
   endtask

   task automatic check_cnt(input string name, input logic [31:0] s, f, w);
      checks++;
      if (StallCycles !== s || FlushCount !== f || MemWaitCycles !== w) begin
         errors++;
         $display("FAIL %s got=%0d/%0d/%0d want=%0d/%0d/%0d", name,
                  StallCycles, FlushCount, MemWaitCycles, s, f, w);
      end
   endtask

   localparam outs_t O_START = {2'b00, 2'b00, 4'b1000, 3'b110, 1'b0};
   localparam outs_t O_ZERO  = '0;
   localparam outs_t O_WREQ  = {2'b00, 2'b00, 4'b1111, 3'b001, 1'b1};
   localparam outs_t O_WAIT  = {2'b00, 2'b00, 4'b1111, 3'b001, 1'b0};
   localparam outs_t O_EXIT  = {2'b00, 2'b00, 4'b1100, 3'b110, 1'b0};

   initial begin
      vec_t tbl[13];
      vin_t m;

      tbl[0]  = '{i: V(0,0,5,0,0,0,0,5,1,5,1), e: {2'b10,2'b00,4'b0000,3'b000,1'b0}};
      tbl[1]  = '{i: V(0,0,5,0,0,0,0,0,1,5,1), e: {2'b01,2'b00,4'b0000,3'b000,1'b0}};
      tbl[2]  = '{i: V(0,0,5,0,0,0,0,0,1,0,1), e: {2'b00,2'b00,4'b0000,3'b000,1'b0}};
      tbl[3]  = '{i: V(0,0,3,9,0,0,0,9,0,9,1), e: {2'b00,2'b01,4'b0000,3'b000,1'b0}};
      tbl[4]  = '{i: V(0,0,4,4,0,0,0,4,1,0,0), e: {2'b10,2'b10,4'b0000,3'b000,1'b0}};
      tbl[5]  = '{i: V(0,0,0,0,0,0,0,0,1,0,1), e: {2'b00,2'b00,4'b0000,3'b000,1'b0}};
      tbl[6]  = '{i: V(0,0,6,8,0,0,0,8,1,6,1), e: {2'b01,2'b10,4'b0000,3'b000,1'b0}};
      tbl[7]  = '{i: V(0,7,0,0,7,1,0,0,0,0,0), e: {2'b00,2'b00,4'b1100,3'b010,1'b0}};
      tbl[8]  = '{i: V(7,0,0,0,7,1,0,0,0,0,0), e: {2'b00,2'b00,4'b1100,3'b010,1'b0}};
      tbl[9]  = '{i: V(0,0,0,0,0,1,0,0,0,0,0), e: {2'b00,2'b00,4'b0000,3'b000,1'b0}};
      tbl[10] = '{i: V(7,0,0,0,7,0,0,0,0,0,0), e: {2'b00,2'b00,4'b0000,3'b000,1'b0}};
      tbl[11] = '{i: V(0,0,0,0,0,0,1,0,0,0,0), e: {2'b00,2'b00,4'b0000,3'b110,1'b0}};
      tbl[12] = '{i: V(0,7,0,0,7,1,1,0,0,0,0), e: {2'b00,2'b00,4'b1100,3'b110,1'b0}};

      // Reset and START
      rst = 1'b0;
      set_in('0);
      @(posedge clk);
      #1;
      check_cnt("rst_cnt", 0, 0, 0);
      apply('0, O_START, 100);             // reset held
      rst = 1'b1;
      apply('0, O_START, 101);             // single START cycle after release
      apply('0, O_ZERO, 102);              // RUN, idle

      // Table-driven combinational checks in RUN
      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].i, tbl[i].e, i);
      end

      // Fresh reset so counters can be checked absolutely
      set_in('0);
      rst = 1'b0;
      #1;
      check_now("rst_again", O_START);
      check_cnt("rst_again_cnt", 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply('0, O_START, 200);
      check_cnt("start_not_counted", 0, 0, 0);
      apply(V(0,0,0,0,0,0,1,0,0,0,0), {2'b00,2'b00,4'b0000,3'b110,1'b0}, 201);
`ifdef HAZARD_PERF_CNT_EN
      check_cnt("branch_cnt", 0, 1, 0);
`else
      check_cnt("branch_cnt", 0, 0, 0);
`endif

      // Access with three wait cycles, branch and load-use held during wait
      m = V(0,7,0,0,7,1,1,0,0,0,0);
      m.macc = 1'b1;
      m.mrdy = 1'b0;
      apply(m, O_WREQ, 300);
      apply(m, O_WAIT, 301);
      apply(m, O_WAIT, 302);
      m.mrdy = 1'b1;
      apply(m, O_EXIT, 303);
      apply('0, O_ZERO, 304);
`ifdef HAZARD_PERF_CNT_EN
      check_cnt("memwait_cnt", 4, 2, 3);
`else
      check_cnt("memwait_cnt", 0, 0, 0);
`endif

      // Zero-wait access: request pulse, no stall
      m = '0;
      m.macc = 1'b1;
      m.mrdy = 1'b1;
      apply(m, {2'b00,2'b00,4'b0000,3'b000,1'b1}, 400);
      apply('0, O_ZERO, 401);

      // Reset dropped mid-MEMWAIT takes effect without a clock edge
      m.mrdy = 1'b0;
      apply(m, O_WREQ, 500);
      check_now("in_memwait", O_WAIT);
      rst = 1'b0;
      #1;
      check_now("async_rst", O_START);
      check_cnt("async_rst_cnt", 0, 0, 0);
      @(posedge clk);
      #1;
      set_in('0);
      rst = 1'b1;
      apply('0, O_START, 501);
      apply('0, O_ZERO, 502);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got=%0d want=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
